// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous program
// memory and presents opcode + optional immediate over valid/ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_addr, mem_ce  memory read address (always pc) and read strobe
//   mem_data_in       memory read data, valid the cycle after mem_ce
//   pc                address of the next byte to fetch
//   inst_out, imm_out opcode and immediate (0x00 for one-byte opcodes)
//   inst_two_byte     presented opcode carries an immediate byte
//   inst_pc           address of the presented opcode byte
//   fetch_valid/ready handshake towards the control unit
//   pc_load(_addr)    branch/jump redirect

module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  input  logic [7:0]        mem_data_in,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        inst_out,
  output logic [7:0]        imm_out,
  output logic              inst_two_byte,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr
);

  localparam logic [2:0] F_OP  = 3'd0;
  localparam logic [2:0] W_OP  = 3'd1;
  localparam logic [2:0] F_IMM = 3'd2;
  localparam logic [2:0] W_IMM = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [7:0]        inst_q, inst_d;
  logic [7:0]        imm_q, imm_d;
  logic              two_q, two_d;
  logic              op_is_two;

  assign op_is_two = (mem_data_in[7:6] == 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    imm_d     = imm_q;
    two_d     = two_q;
    unique case (state_q)
      F_OP: begin
        inst_pc_d = pc_q;
        pc_d      = pc_q + ADDR_W'(1);
        state_d   = W_OP;
      end
      W_OP: begin
        inst_d = mem_data_in;
        two_d  = op_is_two;
        if (op_is_two) begin
          state_d = F_IMM;
        end else begin
          imm_d   = 8'h00;
          state_d = HOLD;
        end
      end
      F_IMM: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = W_IMM;
      end
      W_IMM: begin
        imm_d   = mem_data_in;
        state_d = HOLD;
      end
      HOLD: begin
        if (fetch_ready) state_d = F_OP;
      end
      default: state_d = F_OP;
    endcase
    // A redirect drops the partial instruction and any returning read
    // data; a concurrent HOLD transfer has already been accepted.
    if (pc_load) begin
      state_d   = F_OP;
      pc_d      = pc_load_addr;
      inst_pc_d = inst_pc_q;
      inst_d    = inst_q;
      imm_d     = imm_q;
      two_d     = two_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F_OP;
      pc_q      <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_q    <= 8'h00;
      imm_q     <= 8'h00;
      two_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      imm_q     <= imm_d;
      two_q     <= two_d;
    end
  end

  assign mem_addr      = pc_q;
  assign pc            = pc_q;
  assign mem_ce        = (state_q == F_OP) || (state_q == F_IMM);
  assign fetch_valid   = (state_q == HOLD);
  assign inst_out      = inst_q;
  assign imm_out       = imm_q;
  assign inst_two_byte = two_q;
  assign inst_pc       = inst_pc_q;

endmodule
